axi_wrr_burst_scheduler: RTL and testbench

- Weighted round-robin scheduler that shares one downstream resource (an AXI interconnect address/data channel) between PORTS requesters.
- Grants are transaction-locked: a grant is held from issue until the granted requester's final beat is accepted.
- A per-port weight sets how many consecutive transactions a port may win before priority rotates.
- Sits in front of the interconnect mux; grant/grant_encoded drive the mux select directly.

---
 rtl/axi_wrr_burst_scheduler.sv | 117 +++++++++++
 tb/tb_axi_wrr_burst_scheduler.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/axi_wrr_burst_scheduler.sv
// Weighted round-robin, transaction-locked grant scheduler for a shared AXI channel.
// Define WRR_SCHED_TMR_EN to triplicate all state with majority voting and a tmr_err flag.
module axi_wrr_burst_scheduler #(
  parameter int PORTS    = 4,
  parameter int WEIGHT_W = 4,
  localparam int IDX_W   = $clog2(PORTS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [PORTS-1:0]          request,
  input  logic [PORTS-1:0]          last,
  input  logic                      accept,
  input  logic [PORTS*WEIGHT_W-1:0] weight,
  output logic [PORTS-1:0]          grant,
  output logic                      grant_valid,
  output logic [IDX_W-1:0]          grant_encoded,
  output logic                      tmr_err
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  typedef struct packed {
    state_e              state;
    logic [WEIGHT_W-1:0] credit;
    logic [IDX_W-1:0]    last_port;
    logic [PORTS-1:0]    grant;
    logic                grant_valid;
    logic [IDX_W-1:0]    grant_encoded;
  } st_t;

  localparam st_t RST_ST = '{state: IDLE, credit: '0, last_port: IDX_W'(PORTS-1),
                             grant: '0, grant_valid: 1'b0, grant_encoded: '0};

  st_t                 cur, nxt;
  logic                do_sel;
  logic [IDX_W-1:0]    sel_lp, win;
  logic [WEIGHT_W-1:0] sel_cr, wt;
  int                  idx;

  always_comb begin
    nxt    = cur;
    do_sel = 1'b0;
    sel_lp = cur.last_port;
    sel_cr = cur.credit;
    win    = '0;
    wt     = '0;
    idx    = 0;
    case (cur.state)
      IDLE: do_sel = |request;
      BUSY: begin
        if (accept && last[cur.grant_encoded]) begin
          sel_cr        = (cur.credit != '0) ? cur.credit - WEIGHT_W'(1) : '0;
          sel_lp        = cur.grant_encoded;
          nxt.credit    = sel_cr;
          nxt.last_port = sel_lp;
          if (|request) begin
            do_sel = 1'b1;
          end else begin
            nxt.state       = IDLE;
            nxt.grant       = '0;
            nxt.grant_valid = 1'b0;
          end
        end
      end
      default: nxt = RST_ST;
    endcase

    if (do_sel) begin
      if (request[sel_lp] && sel_cr != '0) begin
        win        = sel_lp;
        nxt.credit = sel_cr;
      end else begin
        // Descending scan so the final hit is the nearest port after sel_lp.
        for (int i = PORTS; i >= 1; i--) begin
          idx = (int'(sel_lp) + i) % PORTS;
          if (request[idx]) win = IDX_W'(idx);
        end
        wt         = weight[int'(win)*WEIGHT_W +: WEIGHT_W];
        nxt.credit = (wt == '0) ? WEIGHT_W'(1) : wt;
      end
      nxt.state         = BUSY;
      nxt.grant         = PORTS'(1) << win;
      nxt.grant_valid   = 1'b1;
      nxt.grant_encoded = win;
    end
  end

`ifdef WRR_SCHED_TMR_EN
  st_t  rep_q [3];
  logic tmr_err_q;

  // All replicas advance from the voted state, so a single upset heals in one edge.
  assign cur = st_t'((rep_q[0] & rep_q[1]) | (rep_q[1] & rep_q[2]) | (rep_q[0] & rep_q[2]));

  always_ff @(posedge clk) begin
    for (int r = 0; r < 3; r++) rep_q[r] <= rst_n ? nxt : RST_ST;
    tmr_err_q <= rst_n ? |((rep_q[0] ^ rep_q[1]) | (rep_q[1] ^ rep_q[2])) : 1'b0;
  end

  assign tmr_err = tmr_err_q;
`else
  st_t cur_q;

  always_ff @(posedge clk) begin
    if (!rst_n) cur_q <= RST_ST;
    else        cur_q <= nxt;
  end

  assign cur     = cur_q;
  assign tmr_err = 1'b0;
`endif

  assign grant         = cur.grant;
  assign grant_valid   = cur.grant_valid;
  assign grant_encoded = cur.grant_encoded;

endmodule

// File: tb/tb_axi_wrr_burst_scheduler.sv
// Bench for axi_wrr_burst_scheduler: directed vector table, a burst sequence,
// then random traffic against a cycle-level reference model.
module tb_axi_wrr_burst_scheduler;
  localparam int PORTS = 4;
  localparam int WW    = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [PORTS-1:0] request, last;
  logic             accept;
  logic [15:0]      weight;
  logic [PORTS-1:0] grant;
  logic             grant_valid;
  logic [1:0]       grant_encoded;
  logic             tmr_err;

  int total = 0;
  int bad   = 0;

  axi_wrr_burst_scheduler #(.PORTS(PORTS), .WEIGHT_W(WW)) dut (
    .clk(clk), .rst_n(rst_n), .request(request), .last(last), .accept(accept),
    .weight(weight), .grant(grant), .grant_valid(grant_valid),
    .grant_encoded(grant_encoded), .tmr_err(tmr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         rst;
    logic [3:0] req, lst;
    bit         acc;
    logic [15:0] wt;
    logic [3:0] eg;
    bit         ev;
    int         ee;
  } vec_t;

  vec_t tbl[$];

  task automatic add(bit rst, logic [3:0] req, logic [3:0] lst, bit acc, logic [15:0] wt,
                     logic [3:0] eg, bit ev, int ee);
    vec_t v;
    v.rst = rst; v.req = req; v.lst = lst; v.acc = acc; v.wt = wt;
    v.eg = eg; v.ev = ev; v.ee = ee;
    tbl.push_back(v);
  endtask

  task automatic check(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(bit rst, logic [3:0] req, logic [3:0] lst, bit acc, logic [15:0] wt);
    rst_n = !rst; request = req; last = lst; accept = acc; weight = wt;
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic check_out(string tag, int eg, int ev, int ee);
    check({tag, ".grant"}, int'(grant), eg);
    check({tag, ".valid"}, int'(grant_valid), ev);
    check({tag, ".enc"}, int'(grant_encoded), ee);
    check({tag, ".tmr_err"}, int'(tmr_err), 0);
  endtask

  // Reference model: integers and a plain modular scan.
  int m_busy, m_cred, m_last, m_gv, m_enc;

  function automatic int wsel(logic [15:0] wv, int p);
    int w;
    w = int'((wv >> (p*WW)) & 16'hF);
    return (w == 0) ? 1 : w;
  endfunction

  task automatic m_reset;
    m_busy = 0; m_cred = 0; m_last = PORTS-1; m_gv = 0; m_enc = 0;
  endtask

  task automatic m_select(logic [3:0] req, logic [15:0] wv);
    int win;
    win = -1;
    if (req[m_last] && m_cred > 0) begin
      win = m_last;
    end else begin
      for (int k = 1; k <= PORTS; k++)
        if (win < 0 && req[(m_last + k) % PORTS]) win = (m_last + k) % PORTS;
      m_cred = wsel(wv, win);
    end
    m_busy = 1; m_gv = 1; m_enc = win;
  endtask

  task automatic m_step(bit rst, logic [3:0] req, logic [3:0] lst, bit acc, logic [15:0] wv);
    if (rst) begin
      m_reset();
    end else if (m_busy == 0) begin
      if (req != 0) m_select(req, wv);
    end else if (acc && lst[m_enc]) begin
      m_cred = (m_cred > 0) ? m_cred - 1 : 0;
      m_last = m_enc;
      if (req != 0) m_select(req, wv);
      else begin m_busy = 0; m_gv = 0; end
    end
  endtask

  initial begin
    drive(1, 0, 0, 0, 16'h1111);
    tick(); tick();

    // single-beat on port 0, then idle
    add(1, 4'b0000, 4'b0000, 0, 16'h1111, 4'b0000, 0, 0);
    add(0, 4'b0001, 4'b0000, 0, 16'h1111, 4'b0001, 1, 0);
    add(0, 4'b0000, 4'b0001, 1, 16'h1111, 4'b0000, 0, 0);
    add(0, 4'b0000, 4'b0000, 0, 16'h1111, 4'b0000, 0, 0);
    // equal weights, all requesting: rotate with no bubble
    add(1, 4'b0000, 4'b0000, 0, 16'h1111, 4'b0000, 0, 0);
    add(0, 4'b1111, 4'b0000, 0, 16'h1111, 4'b0001, 1, 0);
    add(0, 4'b1111, 4'b1111, 1, 16'h1111, 4'b0010, 1, 1);
    add(0, 4'b1111, 4'b1111, 1, 16'h1111, 4'b0100, 1, 2);
    add(0, 4'b1111, 4'b1111, 1, 16'h1111, 4'b1000, 1, 3);
    add(0, 4'b1111, 4'b1111, 1, 16'h1111, 4'b0001, 1, 0);
    // weight[0]=3: 0,0,0,1,0,0,0,1
    add(1, 4'b0000, 4'b0000, 0, 16'h1113, 4'b0000, 0, 0);
    add(0, 4'b0011, 4'b0000, 0, 16'h1113, 4'b0001, 1, 0);
    add(0, 4'b0011, 4'b0011, 1, 16'h1113, 4'b0001, 1, 0);
    add(0, 4'b0011, 4'b0011, 1, 16'h1113, 4'b0001, 1, 0);
    add(0, 4'b0011, 4'b0011, 1, 16'h1113, 4'b0010, 1, 1);
    add(0, 4'b0011, 4'b0011, 1, 16'h1113, 4'b0001, 1, 0);
    add(0, 4'b0011, 4'b0011, 1, 16'h1113, 4'b0001, 1, 0);
    add(0, 4'b0011, 4'b0011, 1, 16'h1113, 4'b0001, 1, 0);
    add(0, 4'b0011, 4'b0011, 1, 16'h1113, 4'b0010, 1, 1);
    // weight[3]=0 acts as 1; enc holds after going idle
    add(1, 4'b0000, 4'b0000, 0, 16'h0111, 4'b0000, 0, 0);
    add(0, 4'b1000, 4'b0000, 0, 16'h0111, 4'b1000, 1, 3);
    add(0, 4'b1000, 4'b1000, 1, 16'h0111, 4'b1000, 1, 3);
    add(0, 4'b0000, 4'b1000, 1, 16'h0111, 4'b0000, 0, 3);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].req, tbl[i].lst, tbl[i].acc, tbl[i].wt);
      tick();
      check_out($sformatf("vec%0d", i), int'(tbl[i].eg), int'(tbl[i].ev), tbl[i].ee);
    end

    // 4-beat burst on port 2, accept toggling, port 1 joins mid-burst
    drive(1, 0, 0, 0, 16'h1111); tick();
    check_out("burst.rst", 0, 0, 0);
    drive(0, 4'b0100, 4'b0000, 0, 16'h1111); tick();
    check_out("burst.g", 4'b0100, 1, 2);
    drive(0, 4'b0100, 4'b0000, 1, 16'h1111); tick();
    check_out("burst.b1", 4'b0100, 1, 2);
    drive(0, 4'b0100, 4'b0100, 0, 16'h1111); tick();
    check_out("burst.noacc", 4'b0100, 1, 2);
    drive(0, 4'b0110, 4'b0000, 1, 16'h1111); tick();
    check_out("burst.b2", 4'b0100, 1, 2);
    drive(0, 4'b0110, 4'b0100, 0, 16'h1111); tick();
    check_out("burst.gap", 4'b0100, 1, 2);
    drive(0, 4'b0110, 4'b0000, 1, 16'h1111); tick();
    check_out("burst.b3", 4'b0100, 1, 2);
    drive(0, 4'b0110, 4'b0000, 0, 16'h1111); tick();
    check_out("burst.gap2", 4'b0100, 1, 2);
    drive(0, 4'b0110, 4'b0100, 1, 16'h1111); tick();
    check_out("burst.b4", 4'b0010, 1, 1);

    // random traffic vs reference model, including occasional mid-burst reset
    drive(1, 0, 0, 0, 16'h1111); m_reset(); tick();
    for (int c = 0; c < 3000; c++) begin
      bit rst;
      logic [3:0] rq, ls;
      bit ac;
      logic [15:0] wv;
      rst = ($urandom_range(0, 199) == 0);
      rq  = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
      ls  = 4'($urandom);
      ac  = $urandom_range(0, 2) != 0;
      wv  = ($urandom_range(0, 15) == 0) ? 16'($urandom) : weight;
      drive(rst, rq, ls, ac, wv);
      m_step(rst, rq, ls, ac, wv);
      tick();
      check_out("rand", m_gv ? (1 << m_enc) : 0, m_gv, m_enc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
